// File: rtl/spu_isa_pkg.sv
// spu_isa_pkg: SPU instruction-set definitions shared by the decode/issue stage.
//   - opcode constants, NOP/LNOP encodings, field bit positions
//     (instruction bit 0 is the MSB, so field [a:b] maps to [31-a:31-b])
//   - pipe enum, decode-info struct and the spu_decode lookup function
package spu_isa_pkg;

  localparam int REG_W = 7;

  localparam logic [31:0] NOP_INSTR  = 32'h4020_0000;  // even-pipe nop
  localparam logic [31:0] LNOP_INSTR = 32'h0020_0000;  // odd-pipe nop

  // Field LSB positions in little-endian numbering
  localparam int RT_LSB     = 0;   // rt[25:31]
  localparam int RA_LSB     = 7;   // ra[18:24]
  localparam int RB_LSB     = 14;  // rb[11:17]
  localparam int OP11_LSB   = 21;  // op[0:10]
  localparam int OP8_LSB    = 24;  // op[0:7]  (RI10 forms)
  localparam int OP4_LSB    = 28;  // op[0:3]  (RRR forms)
  localparam int RRR_RT_LSB = 21;  // rt[4:10] in RRR forms
  localparam int RRR_RC_LSB = 0;   // rc[25:31] in RRR forms

  localparam logic [10:0] OP11_A      = 11'h0C0;
  localparam logic [10:0] OP11_SHLQBY = 11'h1DF;
  localparam logic [10:0] OP11_NOP    = 11'h201;
  localparam logic [10:0] OP11_LNOP   = 11'h001;
  localparam logic [7:0]  OP8_AI      = 8'h1C;
  localparam logic [7:0]  OP8_LQD     = 8'h34;
  localparam logic [7:0]  OP8_STQD    = 8'h24;
  localparam logic [3:0]  OP4_SHUFB   = 4'hB;

  typedef enum logic {PIPE_EVEN = 1'b0, PIPE_ODD = 1'b1} pipe_e;

  typedef struct packed {
    pipe_e            pipe;
    logic [2:0]       lat;
    logic             wr_rt;
    logic             use_ra;
    logic             use_rb;
    logic             use_rc;
    logic             use_rt;   // rt read as a source (stores)
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] rt;
  } dec_t;

  // Unknown opcodes fall through as an even-pipe nop with no register use.
  function automatic dec_t spu_decode(input logic [31:0] ins);
    dec_t d;
    d      = '0;
    d.pipe = PIPE_EVEN;
    d.ra   = ins[RA_LSB +: REG_W];
    d.rb   = ins[RB_LSB +: REG_W];
    d.rt   = ins[RT_LSB +: REG_W];
    if (ins[OP4_LSB +: 4] == OP4_SHUFB) begin
      d.pipe = PIPE_ODD; d.lat = 3'd4; d.wr_rt = 1'b1;
      d.use_ra = 1'b1; d.use_rb = 1'b1; d.use_rc = 1'b1;
      d.rc = ins[RRR_RC_LSB +: REG_W];
      d.rt = ins[RRR_RT_LSB +: REG_W];
    end else begin
      case (ins[OP11_LSB +: 11])
        OP11_A:      begin d.lat = 3'd2; d.wr_rt = 1'b1; d.use_ra = 1'b1; d.use_rb = 1'b1; end
        OP11_SHLQBY: begin d.pipe = PIPE_ODD; d.lat = 3'd4; d.wr_rt = 1'b1;
                           d.use_ra = 1'b1; d.use_rb = 1'b1; end
        OP11_NOP:    d.pipe = PIPE_EVEN;
        OP11_LNOP:   d.pipe = PIPE_ODD;
        default: begin
          case (ins[OP8_LSB +: 8])
            OP8_AI:   begin d.lat = 3'd2; d.wr_rt = 1'b1; d.use_ra = 1'b1; end
            OP8_LQD:  begin d.pipe = PIPE_ODD; d.lat = 3'd6; d.wr_rt = 1'b1; d.use_ra = 1'b1; end
            OP8_STQD: begin d.pipe = PIPE_ODD; d.use_ra = 1'b1; d.use_rt = 1'b1; end
            default:  d.pipe = PIPE_EVEN;
          endcase
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// spu_scoreboard: per-register latency counters for hazard detection.
//   clk, rst           clock, async active-high reset (clears all counters)
//   ld_en/reg/val[1:0] up to two counter loads per cycle (one per issue slot)
//   q_reg[NQ]          registers to query; q_busy[i] = counter of q_reg[i] != 0
module spu_scoreboard #(
  parameter int NREG  = 128,
  parameter int LAT_W = 3,
  parameter int NQ    = 8,
  parameter int RW    = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               ld_en,
  input  logic [1:0][RW-1:0]       ld_reg,
  input  logic [1:0][LAT_W-1:0]    ld_val,
  input  logic [NQ-1:0][RW-1:0]    q_reg,
  output logic [NQ-1:0]            q_busy
);

  logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;

  // A load overrides the decrement of the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      if (ld_en[0] && ld_reg[0] == RW'(r))      cnt_d[r] = ld_val[0];
      else if (ld_en[1] && ld_reg[1] == RW'(r)) cnt_d[r] = ld_val[1];
      else if (cnt_q[r] != '0)                  cnt_d[r] = cnt_q[r] - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    q_busy = '0;
    for (int i = 0; i < NQ; i++) q_busy[i] = (cnt_q[q_reg[i]] != '0);
  end

endmodule

// File: rtl/id_dual_issue.sv
// id_dual_issue: SPU decode/issue stage. Routes the fetched pair (slot1 even
// address, slot2 odd address) to the even/odd pipes, dual-issuing when legal
// and otherwise serialising the pair while holding fetch via stall_if.
//   clk, rst        clock, async active-high reset
//   instr1/instr2   slot1/slot2 instructions; pc_in = PC of slot1
//   find_nop        slot1 is filler, only slot2 is real
//   flush           discard current pair (scoreboard keeps counting)
//   stall_if        combinational fetch hold
//   even_*/odd_*    registered issue ports (NOP/LNOP with valid=0 when empty)
// Optional: ISSUE_STATS_EN adds saturating dual_cnt/single_cnt/stall_cnt ports.
module id_dual_issue
  import spu_isa_pkg::*;
#(
  parameter int NREG  = 128,
  parameter int LAT_W = 3,
  parameter int PC_W  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr1,
  input  logic [31:0]     instr2,
  input  logic [PC_W-1:0] pc_in,
  input  logic            find_nop,
  input  logic            flush,
  output logic            stall_if,
  output logic [31:0]     even_instr,
  output logic            even_valid,
  output logic [PC_W-1:0] even_pc,
  output logic [31:0]     odd_instr,
  output logic            odd_valid,
  output logic [PC_W-1:0] odd_pc
`ifdef ISSUE_STATS_EN
 ,output logic [31:0]     dual_cnt,
  output logic [31:0]     single_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam logic [0:0] ST_PAIR   = 1'b0;  // slot1 not yet issued
  localparam logic [0:0] ST_SECOND = 1'b1;  // slot1 done, slot2 pending

  logic [0:0] state_q, state_d;
  dec_t       d1, d2;

  assign d1 = spu_decode(instr1);
  assign d2 = spu_decode(instr2);

  // Scoreboard queries: [3:0] slot1 {rt,rc,rb,ra}, [7:4] slot2 likewise.
  logic [7:0][REG_W-1:0] q_reg;
  logic [7:0]            q_busy;
  logic [3:0]            use1, use2;
  logic                  haz1, haz2, dep, dual_ok;

  assign q_reg = {d2.rt, d2.rc, d2.rb, d2.ra, d1.rt, d1.rc, d1.rb, d1.ra};
  assign use1  = {d1.wr_rt | d1.use_rt, d1.use_rc, d1.use_rb, d1.use_ra};
  assign use2  = {d2.wr_rt | d2.use_rt, d2.use_rc, d2.use_rb, d2.use_ra};
  assign haz1  = |(q_busy[3:0] & use1);
  assign haz2  = |(q_busy[7:4] & use2);

  // slot2 touching slot1's destination in any way forbids pairing.
  assign dep = d1.wr_rt && ((use2[0] && d2.ra == d1.rt) ||
                            (use2[1] && d2.rb == d1.rt) ||
                            (use2[2] && d2.rc == d1.rt) ||
                            (use2[3] && d2.rt == d1.rt));

  assign dual_ok = (d1.pipe == PIPE_EVEN) && (d2.pipe == PIPE_ODD) &&
                   !haz1 && !haz2 && !dep;

  logic iss1, iss2, stall_raw;

  always_comb begin
    iss1      = 1'b0;
    iss2      = 1'b0;
    stall_raw = 1'b0;
    state_d   = state_q;
    if (flush) begin
      state_d = ST_PAIR;
    end else if (state_q == ST_SECOND || find_nop) begin
      if (haz2) stall_raw = 1'b1;
      else begin
        iss2    = 1'b1;
        state_d = ST_PAIR;
      end
    end else if (dual_ok) begin
      iss1 = 1'b1;
      iss2 = 1'b1;
    end else if (!haz1) begin
      iss1      = 1'b1;
      stall_raw = 1'b1;
      state_d   = ST_SECOND;
    end else begin
      stall_raw = 1'b1;
    end
  end

  // Reset drops the held pair, so fetch is never held during reset.
  assign stall_if = stall_raw & ~rst;

  spu_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .NQ(8)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .ld_en  ({iss2 & d2.wr_rt, iss1 & d1.wr_rt}),
    .ld_reg ({d2.rt, d1.rt}),
    .ld_val ({LAT_W'(d2.lat - 3'd1), LAT_W'(d1.lat - 3'd1)}),
    .q_reg  (q_reg),
    .q_busy (q_busy)
  );

  // Port steering: at most one instruction per pipe is ever issued.
  logic [31:0]     even_instr_d, odd_instr_d;
  logic            even_valid_d, odd_valid_d;
  logic [PC_W-1:0] even_pc_d, odd_pc_d, pc2;

  assign pc2 = pc_in + PC_W'(1);

  always_comb begin
    even_instr_d = NOP_INSTR;  even_valid_d = 1'b0; even_pc_d = '0;
    odd_instr_d  = LNOP_INSTR; odd_valid_d  = 1'b0; odd_pc_d  = '0;
    if (iss1) begin
      if (d1.pipe == PIPE_ODD) begin
        odd_instr_d = instr1; odd_valid_d = 1'b1; odd_pc_d = pc_in;
      end else begin
        even_instr_d = instr1; even_valid_d = 1'b1; even_pc_d = pc_in;
      end
    end
    if (iss2) begin
      if (d2.pipe == PIPE_ODD) begin
        odd_instr_d = instr2; odd_valid_d = 1'b1; odd_pc_d = pc2;
      end else begin
        even_instr_d = instr2; even_valid_d = 1'b1; even_pc_d = pc2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PAIR;
      even_instr <= NOP_INSTR;
      even_valid <= 1'b0;
      even_pc    <= '0;
      odd_instr  <= LNOP_INSTR;
      odd_valid  <= 1'b0;
      odd_pc     <= '0;
    end else begin
      state_q    <= state_d;
      even_instr <= even_instr_d;
      even_valid <= even_valid_d;
      even_pc    <= even_pc_d;
      odd_instr  <= odd_instr_d;
      odd_valid  <= odd_valid_d;
      odd_pc     <= odd_pc_d;
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (iss1 && iss2 && dual_cnt != '1)     dual_cnt   <= dual_cnt + 32'd1;
      if ((iss1 ^ iss2) && single_cnt != '1)  single_cnt <= single_cnt + 32'd1;
      if (stall_if && stall_cnt != '1)        stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_dual_issue.sv
// tb_id_dual_issue: directed + randomized bench for id_dual_issue with a
// reference model based on per-register "free at cycle" times and touched-
// register masks.
module tb_id_dual_issue;

  localparam logic [31:0] NOP  = 32'h4020_0000;
  localparam logic [31:0] LNOP = 32'h0020_0000;

  logic        clk, rst;
  logic [31:0] instr1, instr2;
  logic [9:0]  pc_in;
  logic        find_nop, flush;
  logic        stall_if;
  logic [31:0] even_instr, odd_instr;
  logic        even_valid, odd_valid;
  logic [9:0]  even_pc, odd_pc;
`ifdef ISSUE_STATS_EN
  logic [31:0] dual_cnt, single_cnt, stall_cnt;
`endif

  id_dual_issue dut (
    .clk(clk), .rst(rst), .instr1(instr1), .instr2(instr2), .pc_in(pc_in),
    .find_nop(find_nop), .flush(flush), .stall_if(stall_if),
    .even_instr(even_instr), .even_valid(even_valid), .even_pc(even_pc),
    .odd_instr(odd_instr), .odd_valid(odd_valid), .odd_pc(odd_pc)
`ifdef ISSUE_STATS_EN
   ,.dual_cnt(dual_cnt), .single_cnt(single_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  // reference model state
  int busy_until[128];
  int cycn = 0;
  bit s1done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view of an instruction: pipe, latency, destination and
  // the set of registers it touches (sources plus destination).
  function automatic void ref_dec(input logic [31:0] ins, output bit odd, output int lat,
                                  output bit wr, output logic [6:0] dst, output logic [127:0] m);
    logic [6:0] ra, rb, rt;
    ra = ins[13:7]; rb = ins[20:14]; rt = ins[6:0];
    odd = 0; lat = 0; wr = 0; dst = rt; m = '0;
    if (ins[31:28] == 4'hB) begin               // shufb rt,ra,rb,rc
      odd = 1; lat = 4; wr = 1; dst = ins[27:21];
      m[ra] = 1; m[rb] = 1; m[ins[6:0]] = 1; m[dst] = 1;
    end else if (ins[31:21] == 11'h0C0) begin   // a
      lat = 2; wr = 1; m[ra] = 1; m[rb] = 1; m[rt] = 1;
    end else if (ins[31:21] == 11'h1DF) begin   // shlqby
      odd = 1; lat = 4; wr = 1; m[ra] = 1; m[rb] = 1; m[rt] = 1;
    end else if (ins[31:21] == 11'h201) begin   // nop
      odd = 0;
    end else if (ins[31:21] == 11'h001) begin   // lnop
      odd = 1;
    end else if (ins[31:24] == 8'h1C) begin     // ai
      lat = 2; wr = 1; m[ra] = 1; m[rt] = 1;
    end else if (ins[31:24] == 8'h34) begin     // lqd
      odd = 1; lat = 6; wr = 1; m[ra] = 1; m[rt] = 1;
    end else if (ins[31:24] == 8'h24) begin     // stqd
      odd = 1; m[ra] = 1; m[rt] = 1;
    end
  endfunction

  function automatic bit busy(input logic [127:0] m);
    for (int r = 0; r < 128; r++) if (m[r] && cycn < busy_until[r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] gen();
    logic [6:0] ra, rb, rt, rc;
    ra = 7'($urandom_range(0, 7)); rb = 7'($urandom_range(0, 7));
    rt = 7'($urandom_range(0, 7)); rc = 7'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: return {11'h0C0, rb, ra, rt};
      1: return {8'h1C, 10'($urandom_range(0, 1023)), ra, rt};
      2: return {8'h34, 10'($urandom_range(0, 1023)), ra, rt};
      3: return {8'h24, 10'($urandom_range(0, 1023)), ra, rt};
      4: return {4'hB, rt, rb, ra, rc};
      5: return {11'h1DF, rb, ra, rt};
      6: return NOP;
      7: return LNOP;
      default: return 32'h0;
    endcase
  endfunction

  // One cycle: inputs already driven at the falling edge.
  task automatic step(output bit st);
    bit o1, o2, w1, w2, h1, h2, dep, is1, is2, nxt;
    int l1, l2;
    logic [6:0] t1, t2;
    logic [127:0] m1, m2;
    logic [31:0] ei, oi;
    logic ev, ov;
    logic [9:0] ep, op;
    #1;
    ref_dec(instr1, o1, l1, w1, t1, m1);
    ref_dec(instr2, o2, l2, w2, t2, m2);
    h1 = busy(m1); h2 = busy(m2); dep = w1 && m2[t1];
    is1 = 0; is2 = 0; st = 0; nxt = s1done;
    if (flush) nxt = 0;
    else if (s1done || find_nop) begin
      if (h2) st = 1; else begin is2 = 1; nxt = 0; end
    end else if (!o1 && o2 && !h1 && !h2 && !dep) begin
      is1 = 1; is2 = 1;
    end else if (!h1) begin
      is1 = 1; st = 1; nxt = 1;
    end else st = 1;
    chk("stall_if", stall_if, st);
    @(posedge clk);
    if (is1 && w1) busy_until[t1] = cycn + l1;
    if (is2 && w2) busy_until[t2] = cycn + l2;
    cycn++; s1done = nxt;
    ei = NOP; oi = LNOP; ev = 0; ov = 0; ep = 0; op = 0;
    if (is1) begin
      if (o1) begin ov = 1; oi = instr1; op = pc_in; end
      else    begin ev = 1; ei = instr1; ep = pc_in; end
    end
    if (is2) begin
      if (o2) begin ov = 1; oi = instr2; op = pc_in + 10'd1; end
      else    begin ev = 1; ei = instr2; ep = pc_in + 10'd1; end
    end
    #1;
    chk("even_valid", even_valid, ev);
    chk("even_instr", even_instr, ei);
    chk("odd_valid", odd_valid, ov);
    chk("odd_instr", odd_instr, oi);
    if (ev) chk("even_pc", even_pc, ep);
    if (ov) chk("odd_pc", odd_pc, op);
    @(negedge clk);
  endtask

  task automatic set(input logic [31:0] a, input logic [31:0] b, input logic [9:0] pc,
                     input logic fn, input logic fl);
    instr1 = a; instr2 = b; pc_in = pc; find_nop = fn; flush = fl;
  endtask

  task automatic idle(input int n);
    bit st;
    for (int i = 0; i < n; i++) begin set(NOP, LNOP, 10'h300, 0, 0); step(st); end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ev"}, even_valid, 0);
    chk({tag, "_ov"}, odd_valid, 0);
    chk({tag, "_ei"}, even_instr, NOP);
    chk({tag, "_oi"}, odd_instr, LNOP);
    chk({tag, "_epc"}, even_pc, 0);
    chk({tag, "_opc"}, odd_pc, 0);
    chk({tag, "_stall"}, stall_if, 0);
  endtask

  initial begin
    bit st;
    logic [31:0] A3 = 32'h1800_8083;   // a r3,r1,r2
    logic [31:0] LQ4 = 32'h3400_0284;  // lqd r4,0(r5)
    for (int r = 0; r < 128; r++) busy_until[r] = 0;
    rst = 1; set(NOP, LNOP, 10'h0, 0, 0);
    @(negedge clk);
    chk_reset("reset");
    rst = 0;

    // 1: dual issue
    set(A3, LQ4, 10'h010, 0, 0); step(st);
    chk("t1_ev", even_valid, 1); chk("t1_ov", odd_valid, 1); chk("t1_stall", st, 0);
    idle(7);

    // 2: intra-pair RAW on r3
    set(A3, 32'h3400_0184, 10'h020, 0, 0);
    step(st); chk("t2_ev", even_valid, 1); chk("t2_ov0", odd_valid, 0);
    step(st); chk("t2_ov1", odd_valid, 0);
    step(st); chk("t2_ov2", odd_valid, 1); chk("t2_opc", odd_pc, 10'h021);
    idle(7);

    // 3: structural conflict, two even-pipe adds
    set(A3, {11'h0C0, 7'd5, 7'd4, 7'd6}, 10'h030, 0, 0);
    step(st); chk("t3_ev0", even_valid, 1); chk("t3_ov0", odd_valid, 0);
    step(st); chk("t3_ev1", even_instr, {11'h0C0, 7'd5, 7'd4, 7'd6}); chk("t3_ov1", odd_valid, 0);
    idle(3);

    // 4: find_nop
    set(32'h0, LQ4, 10'h041, 1, 0); step(st);
    chk("t4_ev", even_valid, 0); chk("t4_ei", even_instr, NOP);
    chk("t4_ov", odd_valid, 1); chk("t4_opc", odd_pc, 10'h042);
    idle(7);

    // 5: flush while waiting on slot2
    set(A3, 32'h3400_0184, 10'h050, 0, 0); step(st);
    set(A3, 32'h3400_0184, 10'h050, 0, 1); step(st);
    chk("t5_ev", even_valid, 0); chk("t5_ov", odd_valid, 0);
    set(NOP, LNOP, 10'h100, 0, 0); step(st);
    chk("t5_fresh", st, 0);
    idle(7);

    // 6: reset mid-SECOND with r3 busy from an lqd
    set({8'h34, 10'd0, 7'd5, 7'd3}, {11'h0C0, 7'd3, 7'd3, 7'd6}, 10'h060, 0, 0);
    step(st); step(st);
    rst = 1; #1;
    chk_reset("mid_rst_async");
    @(posedge clk); #1;
    chk_reset("mid_rst_hold");
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < 128; r++) busy_until[r] = 0;
    s1done = 0;
    set({11'h0C0, 7'd3, 7'd3, 7'd6}, LNOP, 10'h070, 0, 0); step(st);
    chk("t6_ev", even_valid, 1); chk("t6_ov", odd_valid, 1); chk("t6_stall", st, 0);

    // randomized traffic; fetch re-presents the pair while stalled
    st = 0;
    for (int n = 0; n < 500; n++) begin
      if (!st) begin
        instr1 = gen(); instr2 = gen();
        pc_in = pc_in + 10'd2;
        find_nop = ($urandom_range(0, 7) == 0);
      end
      flush = ($urandom_range(0, 15) == 0);
      step(st);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
